// File: rtl/dout_shaper_pkg.sv
// Shared encodings for the digital output shaper: FSM states and pin polarity.
package dout_shaper_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_INACT  = 2'd0,
    S_ONDLY  = 2'd1,
    S_ACT    = 2'd2,
    S_OFFDLY = 2'd3
  } state_e;

  localparam logic POL_LOW_ACTIVE  = 1'b0;
  localparam logic POL_HIGH_ACTIVE = 1'b1;

  // Logical activity seen on the pin: ACT and OFFDLY both hold the pin active.
  function automatic logic state_is_active(input state_e st);
    return (st == S_ACT) || (st == S_OFFDLY);
  endfunction

endpackage

// File: rtl/dout_shaper_tick_counter.sv
// Saturating refclk tick counter with synchronous clear and a ">= limit" completion flag.
module dout_shaper_tick_counter #(
  parameter int unsigned BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          tick_i,
  input  logic [BW-1:0] limit_i,
  output logic          done_c
);

  localparam logic [BW-1:0] CNT_MAX = '1;

  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW:0]   cnt_p1;

  // One extra bit so a saturated count still compares as reaching any limit.
  assign cnt_p1 = {1'b0, cnt_q} + (BW+1)'(1);
  assign done_c = tick_i && (cnt_p1 >= {1'b0, limit_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && tick_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dout_shaper.sv
// Digital output driver: on-delay, minimum active width and off-delay in refclk
// ticks, configurable pin polarity, and registered edge pulses / busy flag.
module dout_shaper
  import dout_shaper_pkg::*;
#(
  parameter int unsigned BW     = 8,
  parameter logic        INIVAL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          pol,
  input  logic          refclk,
  input  logic [BW-1:0] on_dly,
  input  logic [BW-1:0] min_on,
  input  logic [BW-1:0] off_dly,
  output logic          pin_out,
  output logic          act,
  output logic          busy,
  output logic          act_edge,
  output logic          inact_edge
);

  state_e        state_q, state_d;
  logic          min_done_q, min_done_d;
  logic          pin_q, act_q, busy_q, act_edge_q, inact_edge_q;
  logic          act_d;
  logic          cnt_clr, cnt_inc, cnt_done;
  logic          min_eff;
  logic [BW-1:0] limit;

  // The single counter serves whichever phase is running.
  always_comb begin
    unique case (state_q)
      S_ONDLY: limit = on_dly;
      S_ACT:   limit = min_on;
      default: limit = off_dly;
    endcase
  end

  dout_shaper_tick_counter #(.BW(BW)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .tick_i  (refclk),
    .limit_i (limit),
    .done_c  (cnt_done)
  );

  assign min_eff = min_done_q || (min_on == '0) || cnt_done;

  always_comb begin
    state_d    = state_q;
    min_done_d = min_done_q;
    cnt_inc    = 1'b0;
    unique case (state_q)
      S_INACT: begin
        if (req) state_d = (on_dly != '0) ? S_ONDLY : S_ACT;
      end
      S_ONDLY: begin
        if (!req)          state_d = S_INACT;
        else if (cnt_done) state_d = S_ACT;
        else               cnt_inc = 1'b1;
      end
      S_ACT: begin
        if (min_eff) begin
          min_done_d = 1'b1;
          if (!req) state_d = (off_dly != '0) ? S_OFFDLY : S_INACT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_OFFDLY: begin
        // Retrigger keeps the minimum width already served.
        if (req) begin
          state_d    = S_ACT;
          min_done_d = 1'b1;
        end else if (cnt_done) begin
          state_d = S_INACT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = S_INACT;
    endcase
    if (state_d == S_INACT) min_done_d = 1'b0;
    cnt_clr = (state_d != state_q);
    act_d   = state_is_active(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INACT;
      min_done_q   <= 1'b0;
      pin_q        <= INIVAL;
      act_q        <= 1'b0;
      busy_q       <= 1'b0;
      act_edge_q   <= 1'b0;
      inact_edge_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_done_q   <= min_done_d;
      pin_q        <= (pol == POL_HIGH_ACTIVE) ? act_d : ~act_d;
      act_q        <= act_d;
      busy_q       <= (state_d != S_INACT);
      act_edge_q   <= act_d & ~act_q;
      inact_edge_q <= ~act_d & act_q;
    end
  end

  assign pin_out    = pin_q;
  assign act        = act_q;
  assign busy       = busy_q;
  assign act_edge   = act_edge_q;
  assign inact_edge = inact_edge_q;

endmodule

// File: tb/tb_dout_shaper.sv
// Directed bench for dout_shaper: per-cycle vector table plus timed scenarios.
module tb_dout_shaper;

  localparam int unsigned BW = 8;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          pol;
  logic          refclk;
  logic [BW-1:0] on_dly;
  logic [BW-1:0] min_on;
  logic [BW-1:0] off_dly;
  logic          pin_out;
  logic          act;
  logic          busy;
  logic          act_edge;
  logic          inact_edge;

  int errors;
  int checks;

  dout_shaper #(.BW(BW), .INIVAL(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .pol        (pol),
    .refclk     (refclk),
    .on_dly     (on_dly),
    .min_on     (min_on),
    .off_dly    (off_dly),
    .pin_out    (pin_out),
    .act        (act),
    .busy       (busy),
    .act_edge   (act_edge),
    .inact_edge (inact_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pin_out, act, busy, act_edge, inact_edge}
  typedef struct {
    logic       r;
    logic       t;
    logic [4:0] exp;
  } vec_t;

  vec_t vt [19];

  function automatic logic [4:0] outs();
    return {pin_out, act, busy, act_edge, inact_edge};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Inputs are changed 1 time unit after the edge; outputs read at the same point.
  task automatic step(input logic r, input logic t);
    req    = r;
    refclk = t;
    @(posedge clk);
    #1;
  endtask

  task automatic scen(input int n, input int per,
                      input int a_lo, input int a_hi, input int b_lo, input int b_hi,
                      output int rise, output int fall, output int n_ae, output int n_ie,
                      output int busy_cyc);
    logic prev;
    logic cur;
    rise = -1; fall = -1; n_ae = 0; n_ie = 0; busy_cyc = 0;
    prev = (pin_out == pol);
    for (int c = 0; c < n; c++) begin
      step(((c >= a_lo) && (c <= a_hi)) || ((c >= b_lo) && (c <= b_hi)),
           (c % per) == (per - 1));
      cur = (pin_out == pol);
      if (cur && !prev && rise < 0) rise = c;
      if (!cur && prev && fall < 0) fall = c;
      prev = cur;
      if (act_edge)   n_ae++;
      if (inact_edge) n_ie++;
      if (busy)       busy_cyc++;
    end
  endtask

  task automatic cfg(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [BW-1:0] c);
    on_dly = a; min_on = b; off_dly = c;
  endtask

  int rise, fall, nae, nie, bcyc;

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; req = 1'b0; refclk = 1'b0; pol = 1'b1;
    cfg(8'd2, 8'd1, 8'd1);

    vt[0]  = '{1'b1, 1'b0, 5'b00100};
    vt[1]  = '{1'b1, 1'b1, 5'b00100};
    vt[2]  = '{1'b1, 1'b0, 5'b00100};
    vt[3]  = '{1'b1, 1'b1, 5'b11110};
    vt[4]  = '{1'b0, 1'b0, 5'b11100};
    vt[5]  = '{1'b0, 1'b1, 5'b11100};
    vt[6]  = '{1'b0, 1'b1, 5'b00001};
    vt[7]  = '{1'b0, 1'b0, 5'b00000};
    vt[8]  = '{1'b1, 1'b1, 5'b00100};
    vt[9]  = '{1'b0, 1'b1, 5'b00000};
    vt[10] = '{1'b1, 1'b0, 5'b00100};
    vt[11] = '{1'b1, 1'b1, 5'b00100};
    vt[12] = '{1'b1, 1'b1, 5'b11110};
    vt[13] = '{1'b1, 1'b1, 5'b11100};
    vt[14] = '{1'b0, 1'b0, 5'b11100};
    vt[15] = '{1'b1, 1'b1, 5'b11100};
    vt[16] = '{1'b0, 1'b0, 5'b11100};
    vt[17] = '{1'b0, 1'b0, 5'b11100};
    vt[18] = '{1'b0, 1'b1, 5'b00001};

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("reset_outputs", 32'(outs()), 32'(5'b00000));
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("idle_after_reset", 32'(outs()), 32'(5'b00000));

    // on=2 min=1 off=1: delays, cancel priority, retrigger from OFFDLY.
    foreach (vt[i]) begin
      step(vt[i].r, vt[i].t);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
    end

    cfg(8'd3, 8'd0, 8'd2);
    scen(80, 4, 0, 39, -1, -1, rise, fall, nae, nie, bcyc);
    chk("delay_rise_cycle", 32'(rise), 32'(11));
    chk("delay_fall_cycle", 32'(fall), 32'(47));
    chk("delay_act_edges",  32'(nae),  32'(1));
    chk("delay_inact_edges", 32'(nie), 32'(1));

    cfg(8'd5, 8'd0, 8'd0);
    scen(30, 4, 0, 7, -1, -1, rise, fall, nae, nie, bcyc);
    chk("glitch_no_rise", 32'(rise), 32'(-1));
    chk("glitch_no_fall", 32'(fall), 32'(-1));
    chk("glitch_edges",   32'(nae + nie), 32'(0));
    chk("glitch_busy_cycles", 32'(bcyc), 32'(8));

    cfg(8'd0, 8'd6, 8'd0);
    scen(40, 4, 0, 0, -1, -1, rise, fall, nae, nie, bcyc);
    chk("minw_rise_cycle", 32'(rise), 32'(0));
    chk("minw_fall_cycle", 32'(fall), 32'(23));

    cfg(8'd0, 8'd3, 8'd4);
    scen(50, 4, 0, 11, 19, 21, rise, fall, nae, nie, bcyc);
    chk("retrig_rise_cycle", 32'(rise), 32'(0));
    chk("retrig_fall_cycle", 32'(fall), 32'(35));
    chk("retrig_act_edges",  32'(nae),  32'(1));
    chk("retrig_inact_edges", 32'(nie), 32'(1));

    // Low-active pin and the largest on-delay.
    pol = 1'b0;
    cfg(8'hFF, 8'd0, 8'd0);
    step(1'b0, 1'b0);
    chk("pol0_idle", 32'(outs()), 32'(5'b10000));
    scen(300, 1, 0, 299, -1, -1, rise, fall, nae, nie, bcyc);
    chk("ondly255_rise_cycle", 32'(rise), 32'(255));
    chk("pol0_active", 32'(outs()), 32'(5'b01100));
    step(1'b0, 1'b0);
    chk("pol0_release", 32'(outs()), 32'(5'b10001));
    pol = 1'b1;
    step(1'b0, 1'b0);
    chk("pol_swap_idle", 32'(outs()), 32'(5'b00000));

    // Asynchronous reset in the middle of an active phase.
    cfg(8'd0, 8'd0, 8'd0);
    step(1'b1, 1'b0);
    chk("pre_reset_active", 32'(outs()), 32'(5'b11110));
    step(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(outs()), 32'(5'b00000));
    #2;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("post_reset_idle", 32'(outs()), 32'(5'b00000));
    step(1'b1, 1'b0);
    chk("post_reset_works", 32'(outs()), 32'(5'b11110));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
